fifo_read_streamer: RTL and testbench

//  Read-side adapter for the asynchronous FIFO. Runs in the FIFO read clock domain.
//  - Drives the FIFO ReadEn/Empty/Data port, which has 1-cycle registered read data.
//  - Presents a valid/ready stream to downstream logic through a 3-entry prefetch buffer.
//  - Frames the stream into fixed-length bursts (Last_out) and keeps a running word count.

---
 rtl/fifo_read_streamer.sv | 109 ++++++++++
 tb/tb_fifo_read_streamer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_streamer.sv
// Read-side adapter for the async FIFO: issues reads against the 1-cycle registered FIFO port,
// buffers up to three words, and presents them as a burst-framed valid/ready stream.
module fifo_read_streamer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [DATA_WIDTH-1:0] Fifo_Data_in,
  input  logic                  Fifo_Empty_in,
  output logic                  Fifo_ReadEn_out,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  Valid_out,
  input  logic                  Ready_in,
  output logic                  Last_out,
  input  logic                  Flush_in,
  output logic [CNT_WIDTH-1:0]  WordCount_out
);

  localparam int unsigned BeatW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BeatW-1:0] BeatLast = BeatW'(BURST_LEN - 1);

  logic [DATA_WIDTH-1:0] buf_q [3];
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [BeatW-1:0]      beat_q, beat_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic       grant, push, pop;
  logic [2:0] pending;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Words already buffered plus the one still coming back from the FIFO must fit in 3 slots.
  assign pending         = {1'b0, occ_q} + {2'b00, inflight_q};
  assign Fifo_ReadEn_out = Reset_n & ~Fifo_Empty_in & ~Flush_in & (pending < 3'd3);
  assign grant           = Fifo_ReadEn_out & ~Fifo_Empty_in;

  assign Valid_out     = (occ_q != 2'd0);
  assign pop           = Valid_out & Ready_in;
  assign push          = inflight_q & ~Flush_in;
  assign Data_out      = buf_q[rd_ptr_q];
  assign Last_out      = Valid_out & (beat_q == BeatLast);
  assign WordCount_out = cnt_q;

  always_comb begin
    occ_d      = occ_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    beat_d     = beat_q;
    inflight_d = grant;
    cnt_d      = pop ? cnt_q + CNT_WIDTH'(1) : cnt_q;

    if (Flush_in) begin
      occ_d    = 2'd0;
      rd_ptr_d = 2'd0;
      wr_ptr_d = 2'd0;
      beat_d   = '0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
        beat_d   = (beat_q == BeatLast) ? '0 : beat_q + BeatW'(1);
      end
      unique case ({push, pop})
        2'b10:   occ_d = occ_q + 2'd1;
        2'b01:   occ_d = occ_q - 2'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      occ_q      <= 2'd0;
      rd_ptr_q   <= 2'd0;
      wr_ptr_q   <= 2'd0;
      inflight_q <= 1'b0;
      beat_q     <= '0;
      cnt_q      <= '0;
    end else begin
      occ_q      <= occ_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      inflight_q <= inflight_d;
      beat_q     <= beat_d;
      cnt_q      <= cnt_d;
    end
  end

  // Storage is cleared too so Data_out reads 0 while reset is held.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 3; i++) begin
        buf_q[i] <= '0;
      end
    end else if (push) begin
      buf_q[wr_ptr_q] <= Fifo_Data_in;
    end
  end

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Directed and randomized checks of fifo_read_streamer against a behavioural FIFO with
// 1-cycle registered read data.
module tb_fifo_read_streamer;

  localparam int unsigned DW = 8;
  localparam int unsigned BL = 4;
  localparam int unsigned CW = 4;

  logic          Clk;
  logic          Reset_n;
  logic [DW-1:0] Fifo_Data_in;
  logic          Fifo_Empty_in;
  logic          Fifo_ReadEn_out;
  logic [DW-1:0] Data_out;
  logic          Valid_out;
  logic          Ready_in;
  logic          Last_out;
  logic          Flush_in;
  logic [CW-1:0] WordCount_out;

  fifo_read_streamer #(
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL),
    .CNT_WIDTH  (CW)
  ) dut (
    .Clk             (Clk),
    .Reset_n         (Reset_n),
    .Fifo_Data_in    (Fifo_Data_in),
    .Fifo_Empty_in   (Fifo_Empty_in),
    .Fifo_ReadEn_out (Fifo_ReadEn_out),
    .Data_out        (Data_out),
    .Valid_out       (Valid_out),
    .Ready_in        (Ready_in),
    .Last_out        (Last_out),
    .Flush_in        (Flush_in),
    .WordCount_out   (WordCount_out)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int unsigned   n_checks;
  int unsigned   n_errors;
  logic [DW-1:0] mq [$];
  logic [DW-1:0] exp_q [$];
  logic          stall_empty;

  // Per-cycle observations, sampled mid-cycle before the active edge.
  logic          o_valid, o_last, o_ren, o_grant, o_pop;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Enter at a negedge; leave at the following negedge.
  task automatic cycle();
    Fifo_Empty_in = stall_empty || (mq.size() == 0);
    #1;
    o_valid = Valid_out;
    o_data  = Data_out;
    o_last  = Last_out;
    o_ren   = Fifo_ReadEn_out;
    o_cnt   = WordCount_out;
    o_grant = Fifo_ReadEn_out & ~Fifo_Empty_in;
    o_pop   = Valid_out & Ready_in;
    @(posedge Clk);
    #1;
    if (o_grant) Fifo_Data_in = mq.pop_front();
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Reset_n      = 1'b0;
    Ready_in     = 1'b0;
    Flush_in     = 1'b0;
    stall_empty  = 1'b0;
    Fifo_Data_in = '0;
    mq.delete();
    cycle();
    cycle();
    Reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int            pops, post, grants, bad, first_c, last_c, guard, beat;
  logic [31:0]   last_mask;
  logic [DW-1:0] first_data, w;
  logic [DW-1:0] got_w [3];
  logic          hold_pend, hold_last;
  logic [DW-1:0] hold_data;

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    Reset_n       = 1'b0;
    Ready_in      = 1'b0;
    Flush_in      = 1'b0;
    stall_empty   = 1'b0;
    Fifo_Data_in  = '0;
    Fifo_Empty_in = 1'b1;
    @(negedge Clk);

    // Reset asserted mid-stream
    do_reset();
    Ready_in = 1'b1;
    for (int i = 1; i <= 6; i++) mq.push_back(8'(i));
    repeat (4) cycle();
    check("pre_rst_valid", 32'(o_valid), 1);
    Reset_n = 1'b0;
    #1;
    check("rst_readen", 32'(Fifo_ReadEn_out), 0);
    check("rst_valid", 32'(Valid_out), 0);
    check("rst_data", 32'(Data_out), 0);
    check("rst_last", 32'(Last_out), 0);
    check("rst_count", 32'(WordCount_out), 0);
    mq.delete();
    cycle();
    cycle();
    Reset_n = 1'b1;
    cycle();
    check("post_rst_valid", 32'(o_valid), 0);
    check("post_rst_readen", 32'(o_ren), 0);

    // Latency and ordering
    do_reset();
    Ready_in = 1'b1;
    cycle();
    check("lat_idle_valid", 32'(o_valid), 0);
    mq.push_back(8'h11);
    mq.push_back(8'h22);
    mq.push_back(8'h33);
    cycle();
    check("lat_t_readen", 32'(o_ren), 1);
    check("lat_t_valid", 32'(o_valid), 0);
    cycle();
    check("lat_t1_valid", 32'(o_valid), 0);
    cycle();
    check("lat_t2_valid", 32'(o_valid), 1);
    check("lat_d0", 32'(o_data), 32'h11);
    cycle();
    check("lat_d1", 32'(o_data), 32'h22);
    cycle();
    check("lat_d2", 32'(o_data), 32'h33);
    check("lat_d2_valid", 32'(o_valid), 1);
    cycle();
    check("lat_end_valid", 32'(o_valid), 0);
    check("lat_count", 32'(o_cnt), 3);

    // Backpressure
    do_reset();
    for (int i = 0; i < 10; i++) mq.push_back(8'(8'hA0 + i));
    grants = 0;
    bad    = 0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (o_grant) grants++;
      if (c >= 2 && !(o_valid && o_data == 8'hA0)) bad++;
    end
    check("bp_grants", 32'(grants), 3);
    check("bp_readen_off", 32'(o_ren), 0);
    check("bp_fifo_left", 32'(mq.size()), 7);
    check("bp_hold_word0", 32'(bad), 0);
    Ready_in = 1'b1;
    pops     = 0;
    bad      = 0;
    first_c  = -1;
    last_c   = -1;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (o_pop) begin
        if (o_data != 8'(8'hA0 + pops)) bad++;
        if (first_c < 0) first_c = c;
        last_c = c;
        pops++;
      end
    end
    check("bp_pops", 32'(pops), 10);
    check("bp_order", 32'(bad), 0);
    check("bp_first_cycle", 32'(first_c), 0);
    check("bp_no_gaps", 32'(last_c - first_c), 9);

    // Burst framing
    do_reset();
    Ready_in = 1'b1;
    for (int i = 0; i < 9; i++) mq.push_back(8'(8'h40 + i));
    pops      = 0;
    last_mask = '0;
    for (int c = 0; c < 16; c++) begin
      cycle();
      if (o_pop) begin
        if (o_last) last_mask[pops] = 1'b1;
        pops++;
      end
    end
    check("burst_pops", 32'(pops), 9);
    check("burst_last_mask", last_mask, 32'h88);

    // Flush mid-burst restarts framing
    do_reset();
    Ready_in = 1'b1;
    for (int i = 0; i < 14; i++) mq.push_back(8'(8'h40 + i));
    pops  = 0;
    guard = 0;
    while (pops < 6 && guard < 40) begin
      cycle();
      if (o_pop) pops++;
      guard++;
    end
    check("flb_pre_pops", 32'(pops), 6);
    Flush_in = 1'b1;
    Ready_in = 1'b0;
    cycle();
    Flush_in   = 1'b0;
    Ready_in   = 1'b1;
    post       = 0;
    last_mask  = '0;
    first_data = '0;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (o_pop) begin
        if (post == 0) first_data = o_data;
        if (o_last) last_mask[post] = 1'b1;
        post++;
      end
    end
    check("flb_post_pops", 32'(post), 6);
    check("flb_first_word", 32'(first_data), 32'h48);
    check("flb_last_mask", last_mask, 32'h08);

    // Flush with a word in flight
    do_reset();
    Ready_in = 1'b1;
    mq.push_back(8'h5A);
    mq.push_back(8'h5B);
    cycle();
    check("fl_grant", 32'(o_grant), 1);
    Flush_in = 1'b1;
    cycle();
    check("fl_no_read", 32'(o_ren), 0);
    Flush_in = 1'b0;
    cycle();
    check("fl_valid_after", 32'(o_valid), 0);
    mq.push_back(8'h66);
    mq.push_back(8'h77);
    pops = 0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (o_pop) begin
        if (pops < 3) got_w[pops] = o_data;
        pops++;
      end
    end
    check("fl_pops", 32'(pops), 3);
    check("fl_w0", 32'(got_w[0]), 32'h5B);
    check("fl_w1", 32'(got_w[1]), 32'h66);
    check("fl_w2", 32'(got_w[2]), 32'h77);

    // Counter wrap
    do_reset();
    Ready_in = 1'b1;
    for (int i = 0; i < 17; i++) mq.push_back(8'(i));
    pops = 0;
    for (int c = 0; c < 25; c++) begin
      cycle();
      if (o_pop) pops++;
    end
    check("wrap_pops", 32'(pops), 17);
    check("wrap_count", 32'(o_cnt), 1);

    // Randomized traffic against a scoreboard
    do_reset();
    exp_q.delete();
    hold_pend = 1'b0;
    hold_data = '0;
    hold_last = 1'b0;
    beat      = 0;
    for (int c = 0; c < 10040; c++) begin
      if (c < 10000) begin
        Ready_in    = ($urandom_range(0, 3) != 0);
        stall_empty = ($urandom_range(0, 4) == 0);
        if (mq.size() < 8 && $urandom_range(0, 2) != 0) begin
          w = 8'($urandom);
          mq.push_back(w);
          exp_q.push_back(w);
        end
      end else begin
        Ready_in    = 1'b1;
        stall_empty = 1'b0;
      end
      cycle();
      if (hold_pend) begin
        check("hold_valid", 32'(o_valid), 1);
        check("hold_data", 32'(o_data), 32'(hold_data));
        check("hold_last", 32'(o_last), 32'(hold_last));
      end
      check("rnd_last", 32'(o_last), 32'(o_valid && beat == int'(BL) - 1));
      hold_pend = o_valid & ~o_pop;
      hold_data = o_data;
      hold_last = o_last;
      if (o_pop) begin
        beat = (beat == int'(BL) - 1) ? 0 : beat + 1;
        if (exp_q.size() == 0) check("sb_extra_word", 1, 0);
        else check("sb_data", 32'(o_data), 32'(exp_q.pop_front()));
      end
    end
    check("sb_words_left", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
